// File: rtl/dlk_pkg.sv
// Shared types and constants for the DLK bounds table and its LSU-side checker.
package dlk_pkg;

    // Default address width (XLEN).
    localparam int DLK_AW = 32;

    // One table entry: the valid bit lets base address 0 be a legal allocation.
    typedef struct packed {
        logic              valid;
        logic [DLK_AW-1:0] base;
    } dlk_entry_t;

    // All-ones pattern for an aw-bit limit, meaning no higher block exists.
    function automatic logic [63:0] dlkLimitNone(input int aw);
        if (aw >= 64) begin
            return '1;
        end
        return (64'd1 << aw) - 64'd1;
    endfunction

endpackage

// File: rtl/dlk_min_above.sv
// Combinational search for the smallest valid base strictly above a key.
// Returns all-ones when nothing qualifies; o_found tells that case apart
// from a real entry whose base happens to be all-ones.
module dlk_min_above
    import dlk_pkg::*;
#(
    parameter int AW    = DLK_AW,
    parameter int DEPTH = 32
) (
    input  logic [DEPTH-1:0] i_valid,
    input  logic [AW-1:0]    i_base [DEPTH],
    input  logic [AW-1:0]    i_key,
    output logic [AW-1:0]    o_limit,
    output logic             o_found
);

    localparam logic [AW-1:0] LIMIT_NONE = AW'(dlkLimitNone(AW));

    // Linear scan keeping the running minimum of qualifying bases.
    always_comb begin
        o_limit = LIMIT_NONE;
        o_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_valid[i] && (i_base[i] > i_key) &&
                (!o_found || (i_base[i] < o_limit))) begin
                o_limit = i_base[i];
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bounds_table_dlk.sv
// Bounds table for DLK data blocks: a circular buffer of allocated base
// addresses with per-entry valid bits, explicit free, synchronous flush and
// a one-cycle registered overflow check for LSU accesses.
// Optional feature macro: DLK_OVF_CNT_EN enables the saturating overflow
// counter on ovf_count_o; without it the output is tied to zero.
module bounds_table_dlk
    import dlk_pkg::*;
#(
    parameter int AW    = DLK_AW,
    parameter int DEPTH = 32,
    parameter int CW    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       alloc_valid_i,
    input  logic [AW-1:0]              alloc_base_i,
    input  logic                       free_valid_i,
    input  logic [AW-1:0]              free_base_i,
    input  logic                       chk_valid_i,
    input  logic [AW-1:0]              chk_base_i,
    input  logic [AW-1:0]              chk_addr_i,
    output logic                       chk_valid_o,
    output logic                       chk_overflow_o,
    output logic [AW-1:0]              chk_limit_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [AW-1:0]              last_base_o,
    output logic [CW-1:0]              ovf_count_o
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CNTW       = $clog2(DEPTH+1);
    localparam logic [AW-1:0]   LIMIT_NONE = AW'(dlkLimitNone(AW));

    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_base [DEPTH];
    logic [PW-1:0]    r_cursor;
    logic [AW-1:0]    r_lastBase;
    logic             r_chkValid;
    logic             r_chkOverflow;
    logic [AW-1:0]    r_chkLimit;

    logic [AW-1:0]    w_limit;
    logic             w_found;
    logic             w_overflow;
    logic             w_allocHit;
    logic             w_allocDo;
    logic [CNTW-1:0]  w_count;

    dlk_min_above #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_minAbove (
        .i_valid (r_valid),
        .i_base  (r_base),
        .i_key   (chk_base_i),
        .o_limit (w_limit),
        .o_found (w_found)
    );

    // A base of all-ones can never be exceeded, so it never flags overflow.
    assign w_overflow = chk_valid_i && w_found && (w_limit != LIMIT_NONE) &&
                        (chk_addr_i >= w_limit);

    // Duplicate allocs are ignored so each base lives in at most one slot.
    always_comb begin
        w_allocHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_base[i] == alloc_base_i)) begin
                w_allocHit = 1'b1;
            end
        end
    end

    // Freeing the very base being allocated cancels the alloc.
    assign w_allocDo = alloc_valid_i && !w_allocHit &&
                       !(free_valid_i && (free_base_i == alloc_base_i));

    // Popcount of the valid bits gives the live entry count.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNTW'(r_valid[i]);
        end
    end

    // Table state and registered check results; the alloc write is ordered
    // after the free loop so it wins when both hit the cursor slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid       <= '0;
            r_cursor      <= '0;
            r_lastBase    <= '0;
            r_chkValid    <= 1'b0;
            r_chkOverflow <= 1'b0;
            r_chkLimit    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_base[i] <= '0;
            end
        end else if (flush_i) begin
            r_valid       <= '0;
            r_cursor      <= '0;
            r_lastBase    <= '0;
            r_chkValid    <= 1'b0;
            r_chkOverflow <= 1'b0;
            r_chkLimit    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_base[i] <= '0;
            end
        end else begin
            r_chkValid <= chk_valid_i;
            if (chk_valid_i) begin
                r_chkLimit    <= w_limit;
                r_chkOverflow <= w_overflow;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (free_valid_i && r_valid[i] && (r_base[i] == free_base_i)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_allocDo) begin
                r_valid[r_cursor] <= 1'b1;
                r_base[r_cursor]  <= alloc_base_i;
                r_cursor          <= r_cursor + 1'b1;
                r_lastBase        <= alloc_base_i;
            end
        end
    end

    assign chk_valid_o    = r_chkValid;
    assign chk_overflow_o = r_chkOverflow;
    assign chk_limit_o    = r_chkLimit;
    assign count_o        = w_count;
    assign last_base_o    = r_lastBase;

`ifdef DLK_OVF_CNT_EN
    logic [CW-1:0] r_ovfCount;

    // Count every cycle that presents a valid overflowing result, saturating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovfCount <= '0;
        end else if (flush_i) begin
            r_ovfCount <= '0;
        end else if (r_chkValid && r_chkOverflow && (r_ovfCount != '1)) begin
            r_ovfCount <= r_ovfCount + 1'b1;
        end
    end

    assign ovf_count_o = r_ovfCount;
`else
    assign ovf_count_o = '0;
`endif

endmodule

// File: tb/tb_bounds_table_dlk.sv
// Directed testbench for bounds_table_dlk with a 4-entry table and a 2-bit
// overflow counter. Expected values are hand-computed per vector.
module tb_bounds_table_dlk;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          allocValid;
    logic [AW-1:0] allocBase;
    logic          freeValid;
    logic [AW-1:0] freeBase;
    logic          chkValidIn;
    logic [AW-1:0] chkBase;
    logic [AW-1:0] chkAddr;
    logic          chkValidOut;
    logic          chkOverflow;
    logic [AW-1:0] chkLimit;
    logic [2:0]    countOut;
    logic [AW-1:0] lastBase;
    logic [CW-1:0] ovfCount;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic        fl;
        logic        av;
        logic [31:0] ab;
        logic        fv;
        logic [31:0] fb;
        logic        cv;
        logic [31:0] cb;
        logic [31:0] ca;
        logic        eValid;
        logic        eOvf;
        logic [31:0] eLimit;
        logic [2:0]  eCount;
        logic [31:0] eLast;
    } vec_t;

    vec_t vecs[$];

    bounds_table_dlk #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .alloc_valid_i  (allocValid),
        .alloc_base_i   (allocBase),
        .free_valid_i   (freeValid),
        .free_base_i    (freeBase),
        .chk_valid_i    (chkValidIn),
        .chk_base_i     (chkBase),
        .chk_addr_i     (chkAddr),
        .chk_valid_o    (chkValidOut),
        .chk_overflow_o (chkOverflow),
        .chk_limit_o    (chkLimit),
        .count_o        (countOut),
        .last_base_o    (lastBase),
        .ovf_count_o    (ovfCount)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic fl, input logic av, input logic [31:0] ab,
                                input logic fv, input logic [31:0] fb,
                                input logic cv, input logic [31:0] cb, input logic [31:0] ca,
                                input logic eValid, input logic eOvf, input logic [31:0] eLimit,
                                input logic [2:0] eCount, input logic [31:0] eLast);
        vec_t v;
        v.fl = fl; v.av = av; v.ab = ab; v.fv = fv; v.fb = fb;
        v.cv = cv; v.cb = cb; v.ca = ca;
        v.eValid = eValid; v.eOvf = eOvf; v.eLimit = eLimit;
        v.eCount = eCount; v.eLast = eLast;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idleInputs();
        flush = 1'b0; allocValid = 1'b0; allocBase = '0;
        freeValid = 1'b0; freeBase = '0;
        chkValidIn = 1'b0; chkBase = '0; chkAddr = '0;
    endtask

    // Drive one vector at the falling edge and let it take effect on the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        flush = v.fl; allocValid = v.av; allocBase = v.ab;
        freeValid = v.fv; freeBase = v.fb;
        chkValidIn = v.cv; chkBase = v.cb; chkAddr = v.ca;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, ".chkValid"}, {31'd0, chkValidOut}, {31'd0, v.eValid});
        checkOutput({tag, ".overflow"}, {31'd0, chkOverflow}, {31'd0, v.eOvf});
        checkOutput({tag, ".limit"}, chkLimit, v.eLimit);
        checkOutput({tag, ".count"}, {29'd0, countOut}, {29'd0, v.eCount});
        checkOutput({tag, ".lastBase"}, lastBase, v.eLast);
    endtask

    task automatic stepIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idleInputs();
        end
    endtask

    initial begin
        logic [CW-1:0] expOvfSat;
        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.chkValid", {31'd0, chkValidOut}, 32'd0);
        checkOutput("reset.overflow", {31'd0, chkOverflow}, 32'd0);
        checkOutput("reset.limit", chkLimit, 32'd0);
        checkOutput("reset.count", {29'd0, countOut}, 32'd0);
        checkOutput("reset.lastBase", lastBase, 32'd0);
        checkOutput("reset.ovfCount", {30'd0, ovfCount}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //            fl  av  ab            fv  fb            cv  cb            ca             eV  eO  eLimit        eC    eLast
        vecs.push_back(mk(0, 1, 32'h0000_0000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 0, 32'h0,        3'd1, 32'h0000_0000));
        vecs.push_back(mk(0, 1, 32'h0000_1000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 0, 32'h0,        3'd2, 32'h0000_1000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0000_0FFC, 1, 0, 32'h0000_1000, 3'd2, 32'h0000_1000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0000_1000, 1, 1, 32'h0000_1000, 3'd2, 32'h0000_1000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0000_1004, 1, 1, 32'h0000_1000, 3'd2, 32'h0000_1000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h0,         0, 1, 32'h0000_1000, 3'd2, 32'h0000_1000));
        vecs.push_back(mk(0, 1, 32'h0000_2000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 1, 32'h0000_1000, 3'd3, 32'h0000_2000));
        vecs.push_back(mk(0, 1, 32'h0000_2000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 1, 32'h0000_1000, 3'd3, 32'h0000_2000));
        vecs.push_back(mk(0, 1, 32'h0000_3000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 1, 32'h0000_1000, 3'd4, 32'h0000_3000));
        vecs.push_back(mk(0, 1, 32'h0000_4000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 1, 32'h0000_1000, 3'd4, 32'h0000_4000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_3000, 32'h0000_4000, 1, 1, 32'h0000_4000, 3'd4, 32'h0000_4000));
        vecs.push_back(mk(0, 1, 32'h0000_0000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 1, 32'h0000_4000, 3'd4, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0000_1800, 1, 0, 32'h0000_2000, 3'd4, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_2000, 0, 32'h0,       32'h0,         0, 0, 32'h0000_2000, 3'd3, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 32'h0,         1, 32'h0000_5555, 0, 32'h0,       32'h0,         0, 0, 32'h0000_2000, 3'd3, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0000_3000, 1, 1, 32'h0000_3000, 3'd3, 32'h0000_0000));
        vecs.push_back(mk(0, 1, 32'h0000_5000, 1, 32'h0000_4000, 0, 32'h0,       32'h0,         0, 1, 32'h0000_3000, 3'd3, 32'h0000_5000));
        vecs.push_back(mk(0, 1, 32'h0000_6000, 1, 32'h0000_3000, 0, 32'h0,       32'h0,         0, 1, 32'h0000_3000, 3'd3, 32'h0000_6000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_5000, 32'h0000_6000, 1, 1, 32'h0000_6000, 3'd3, 32'h0000_6000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0000_4FFF, 1, 0, 32'h0000_5000, 3'd3, 32'h0000_6000));
        vecs.push_back(mk(0, 1, 32'h0000_7000, 1, 32'h0000_7000, 0, 32'h0,       32'h0,         0, 0, 32'h0000_5000, 3'd3, 32'h0000_6000));
        vecs.push_back(mk(0, 1, 32'h0000_0000, 1, 32'h0000_0000, 0, 32'h0,       32'h0,         0, 0, 32'h0000_5000, 3'd2, 32'h0000_6000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_6000, 32'hFFFF_0000, 1, 0, ONES,         3'd2, 32'h0000_6000));
        vecs.push_back(mk(0, 1, 32'h0000_7000, 0, 32'h0,        1, 32'h0000_6000, 32'h0000_8000, 1, 0, ONES,         3'd3, 32'h0000_7000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_6000, 32'h0000_7000, 1, 1, 32'h0000_7000, 3'd3, 32'h0000_7000));
        vecs.push_back(mk(1, 1, 32'h0000_9000, 0, 32'h0,        1, 32'h0000_6000, 32'h0000_7000, 0, 0, 32'h0,        3'd0, 32'h0000_0000));
        vecs.push_back(mk(0, 1, 32'h0000_0000, 0, 32'h0,        0, 32'h0,        32'h0,         0, 0, 32'h0,        3'd1, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        32'h0000_0010, 1, 0, ONES,         3'd1, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        ONES,          1, 0, ONES,         3'd1, 32'h0000_0000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Async reset asserted between edges clears outputs without a clock.
        @(negedge clk);
        idleInputs();
        chkValidIn = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst.chkValid", {31'd0, chkValidOut}, 32'd0);
        checkOutput("asyncRst.limit", chkLimit, 32'd0);
        checkOutput("asyncRst.count", {29'd0, countOut}, 32'd0);
        @(negedge clk);
        idleInputs();
        rst = 1'b0;

        // Five consecutive overflowing checks drive the 2-bit counter into saturation.
        applyStimulus(mk(0, 1, 32'h0000_0000, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 3'd1, 32'h0));
        applyStimulus(mk(0, 1, 32'h0000_1000, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 3'd2, 32'h0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0000_1000, 1, 1, 32'h0000_1000, 3'd2, 32'h0000_1000));
        end
        checkOutput("ovfSeq.overflow", {31'd0, chkOverflow}, 32'd1);
`ifdef DLK_OVF_CNT_EN
        checkOutput("ovfSeq.countAfter5Edges", {30'd0, ovfCount}, 32'd3);
        expOvfSat = 2'd3;
`else
        checkOutput("ovfSeq.countTied", {30'd0, ovfCount}, 32'd0);
        expOvfSat = 2'd0;
`endif
        stepIdle(1);
        @(posedge clk);
        #1;
        checkOutput("ovfSeq.saturated", {30'd0, ovfCount}, {30'd0, expOvfSat});
        checkOutput("ovfSeq.validDrops", {31'd0, chkValidOut}, 32'd0);

        @(negedge clk);
        idleInputs();
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush.ovfCount", {30'd0, ovfCount}, 32'd0);
        checkOutput("flush.count", {29'd0, countOut}, 32'd0);
        @(negedge clk);
        idleInputs();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bounds_table_dlk.md
Name: bounds_table_dlk

Overview:
- Parametrised successor of the DLK base-address circular buffer: tracks up to DEPTH allocated data-block base addresses.
- Flags loads/stores that run past the end of their block into the next allocated block.
- Adds per-entry valid bits, so address 0 is a legal base. Adds explicit free, synchronous flush and a registered check pipeline stage. Oldest entry is overwritten when full.
- Sits beside the LSU; alloc/free are driven by the custom DLK instructions, check by each memory access.

Parameters:
AW, 32, address width (XLEN)
DEPTH, 32, table entries; power of two, >= 2
CW, 16, overflow-counter width (used only with DLK_OVF_CNT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  synchronous clear of the whole table (debug instruction)
alloc_valid_i  in  1  insert alloc_base_i this cycle
alloc_base_i  in  AW  base address to insert
free_valid_i  in  1  invalidate entry matching free_base_i
free_base_i  in  AW  base address to remove
chk_valid_i  in  1  check request
chk_base_i  in  AW  base of the block being accessed
chk_addr_i  in  AW  accessed address
chk_valid_o  out  1  check result valid (1 cycle after chk_valid_i)
chk_overflow_o  out  1  access crosses into next allocated block
chk_limit_o  out  AW  next-higher valid base, or all-ones if none
count_o  out  $clog2(DEPTH+1)  number of valid entries
last_base_o  out  AW  most recently written base (debug)
ovf_count_o  out  CW  saturating overflow count

Behaviour:
- Reset (rst_i=1, async): all valid bits 0, bases 0, cursor 0. Outputs: chk_valid_o=0, chk_overflow_o=0, chk_limit_o=0, last_base_o=0, ovf_count_o=0; count_o=0.
- flush_i (sync): same clearing as reset on the next edge. Has priority over alloc/free/check; chk_valid_o=0 the following cycle.
- Alloc:
  - alloc_base_i matches a valid entry (pre-edge state): no-op.
  - Otherwise write {valid=1, base} at cursor, cursor = (cursor+1) mod DEPTH, last_base_o = base.
  - Full table: the cursor slot holds the oldest entry and is overwritten; count stays DEPTH.
- Free: clear the valid bit of the matching valid entry. No match: no-op. Cursor is unchanged; freed slots are reused only when the cursor reaches them.
- Alloc and free in the same cycle:
  - Equal bases: free wins and alloc is dropped.
  - Different bases: both apply. If the cursor slot is the one being freed, the alloc write wins on that slot.
- count_o: combinational popcount of the valid bits; no arithmetic corner cases.
- Check, latency 1:
  - Searches the pre-edge table (ignores same-cycle alloc/free).
  - limit = minimum valid base strictly greater than chk_base_i, or all-ones if none.
  - overflow = chk_valid_i && (chk_addr_i >= limit) && (limit != all-ones).
  - chk_limit_o and chk_overflow_o update only when chk_valid_i=1 and hold otherwise. chk_valid_o is a registered copy of chk_valid_i.
- All address comparisons are unsigned, AW bits.

Optional Feature:
- DLK_OVF_CNT_EN defined: ovf_count_o increments on each cycle where chk_valid_o && chk_overflow_o. It saturates at 2^CW-1 and is cleared by reset and flush.
- Not defined: counter logic absent; ovf_count_o tied to 0.

Decomposition:
- Package dlk_pkg:
  - DLK_AW default constant.
  - dlk_entry_t struct {logic valid; logic [AW-1:0] base}.
  - Helper function for the all-ones limit constant.
- Sub-module dlk_min_above: combinational search over DEPTH entries, returning limit plus a found flag. Reused by the LSU-side checker.

Test Plan:
- Reset, then alloc 0x0 and 0x1000. Check base=0x0, addr=0x0FFC -> overflow=0, limit=0x1000. Check addr=0x1000 -> overflow=1; check addr=0x1004 -> overflow=1.
- Alloc 0x2000 twice -> count_o=1; cursor advanced once (last_base_o=0x2000; next alloc 0x3000 lands in slot 1).
- DEPTH=4: alloc 0x100, 0x200, 0x300, 0x400, 0x500 -> count_o=4, 0x100 evicted. Check base=0x0, addr=0x150 -> limit=0x200, overflow=0.
- Alloc 0x1000, then same cycle alloc 0x1000 + free 0x1000 -> entry invalid, count_o=0. Check base=0x0, addr=0xFFFF_0000 -> limit=0xFFFF_FFFF, overflow=0.
- Assert rst_i mid-sequence between edges -> outputs zero immediately. flush_i with chk_valid_i=1 -> chk_valid_o=0 next cycle, count_o=0.
- With DLK_OVF_CNT_EN and CW=2: 5 overflowing checks -> ovf_count_o=3; flush -> 0.
